// File: rtl/press_classifier.sv
// Turns debounced press/release events into short, double and long(+repeat) gesture pulses.
// One shared counter times the active phase; it restarts on every state change.
module press_classifier #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int DOUBLE_CYC = 25_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int CNT_W      = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_state,
  input  logic i_ondn,
  input  logic i_onup,
  output logic o_short,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESS1   = 3'd1;
  localparam logic [2:0] S_GAP      = 3'd2;
  localparam logic [2:0] S_LONG     = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DOUBLE_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_q, init_d;
  logic             short_q, short_d, double_q, double_d;
  logic             long_q, long_d, repeat_q, repeat_d, held_q, held_d;
  logic             dn, up;

  // Simultaneous press and release is treated as noise.
  assign dn = i_ondn & ~i_onup;
  assign up = i_onup & ~i_ondn;

  always_comb begin
    state_d  = state_q;
    init_d   = 1'b0;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    if (init_q) begin
      // A button already down when reset drops must not produce a gesture.
      state_d = i_state ? S_WAIT_REL : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (dn) state_d = S_PRESS1;
        S_PRESS1: begin
          if (up) state_d = S_GAP;
          else if (cnt_q == LONG_LAST) begin
            state_d = S_LONG;
            long_d  = 1'b1;
          end
        end
        S_GAP: begin
          if (dn) begin
            state_d  = S_WAIT_REL;
            double_d = 1'b1;
          end else if (cnt_q == DBL_LAST) begin
            state_d = S_IDLE;
            short_d = 1'b1;
          end
        end
        S_LONG: begin
          if (up) state_d = S_IDLE;
          else if (cnt_q == REP_LAST) repeat_d = 1'b1;
        end
        S_WAIT_REL: if (up) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    else if (state_q == S_LONG && cnt_q == REP_LAST) cnt_d = '0;
    else if (state_q == S_PRESS1 || state_q == S_GAP || state_q == S_LONG)
      cnt_d = cnt_q + CNT_W'(1);
    else cnt_d = '0;

    held_d = (state_d == S_LONG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      init_q   <= 1'b1;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      init_q   <= init_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign o_short  = short_q;
  assign o_double = double_q;
  assign o_long   = long_q;
  assign o_repeat = repeat_q;
  assign o_held   = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Gesture classifier bench: scenario table, reset sequence, and random button activity
// compared against a timestamp-based reference model.
module tb_press_classifier;
  localparam int LC = 16, DC = 8, RC = 4;

  logic clk = 1'b0;
  logic rst, i_state, i_ondn, i_onup;
  logic o_short, o_double, o_long, o_repeat, o_held;

  press_classifier #(.LONG_CYC(LC), .DOUBLE_CYC(DC), .REPEAT_CYC(RC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_state(i_state), .i_ondn(i_ondn), .i_onup(i_onup),
    .o_short(o_short), .o_double(o_double), .o_long(o_long), .o_repeat(o_repeat),
    .o_held(o_held)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model: remembers when the current gesture's press/release/long events happened.
  bit   m_init, m_wait;
  int   m_t, m_pdn, m_pup, m_long;
  logic [4:0] m_exp;  // {short, double, long, repeat, held}

  task automatic model_step();
    logic mdn, mup;
    mdn = i_ondn & ~i_onup;
    mup = i_onup & ~i_ondn;
    m_exp = '0;
    if (rst) begin
      m_init = 1; m_wait = 0; m_pdn = -1; m_pup = -1; m_long = -1;
    end else if (m_init) begin
      m_init = 0; m_wait = i_state;
    end else if (m_wait) begin
      if (mup) m_wait = 0;
    end else if (m_long >= 0) begin
      if (mup) m_long = -1;
      else begin
        m_exp[0] = 1'b1;
        if ((m_t + 1 - m_long) % RC == 0) m_exp[1] = 1'b1;
      end
    end else if (m_pup >= 0) begin
      if (mdn) begin m_exp[3] = 1'b1; m_wait = 1; m_pup = -1; end
      else if (m_t - m_pup == DC) begin m_exp[4] = 1'b1; m_pup = -1; end
    end else if (m_pdn >= 0) begin
      if (mup) begin m_pup = m_t; m_pdn = -1; end
      else if (m_t - m_pdn == LC) begin
        m_exp[2] = 1'b1; m_exp[0] = 1'b1; m_long = m_t + 1; m_pdn = -1;
      end
    end else if (mdn) m_pdn = m_t;
    m_t++;
  endtask

  task automatic chk(input string name, input int cyc, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b (short,double,long,repeat,held)", name, cyc, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {o_short, o_double, o_long, o_repeat, o_held};
  endfunction

  // Apply one cycle of inputs, advance the model, check DUT against it after the edge.
  task automatic tick(input logic r, input logic s, input logic dn, input logic up);
    rst = r; i_state = s; i_ondn = dn; i_onup = up;
    model_step();
    @(posedge clk);
    #1;
    chk("model", m_t, outs(), m_exp);
  endtask

  typedef struct {
    string name;
    int up1, dn2, up2, len;
    int short_at, dbl_at, long_at, held_lo, held_hi, rep_lo;
  } scen_t;

  scen_t sc[7];

  initial begin
    int nshort;
    logic lvl;
    int dur;

    sc[0] = '{"short",        5, -1, -1, 20, 14, -1, -1, -1, -1, -1};
    sc[1] = '{"double",       5,  9, 30, 36, -1, 10, -1, -1, -1, -1};
    sc[2] = '{"long_repeat", 30, -1, -1, 40, -1, -1, 17, 17, 30, 21};
    sc[3] = '{"rel_vs_long", 16, -1, -1, 30, 25, -1, -1, -1, -1, -1};
    sc[4] = '{"dn_vs_gap",    3, 11, 15, 20, -1, 12, -1, -1, -1, -1};
    sc[5] = '{"rel_before",  15, -1, -1, 30, 24, -1, -1, -1, -1, -1};
    sc[6] = '{"rel_after",   17, -1, -1, 25, -1, -1, 17, 17, 17, -1};

    m_t = 0; m_init = 1; m_wait = 0; m_pdn = -1; m_pup = -1; m_long = -1;
    rst = 1; i_state = 0; i_ondn = 0; i_onup = 0;
    tick(1, 0, 0, 0);
    chk("reset_state", 0, outs(), 5'b0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("post_reset_cycle", 0, outs(), 5'b0);

    for (int k = 0; k < 7; k++) begin
      for (int c = 0; c < sc[k].len; c++) begin
        logic dn, up, st;
        logic [4:0] e;
        int n;
        dn = (c == 0) || (c == sc[k].dn2);
        up = (c == sc[k].up1) || (c == sc[k].up2);
        st = (c < sc[k].up1) || (sc[k].dn2 >= 0 && c >= sc[k].dn2 && c < sc[k].up2);
        tick(0, st, dn, up);
        n = c + 1;
        e[4] = (n == sc[k].short_at);
        e[3] = (n == sc[k].dbl_at);
        e[2] = (n == sc[k].long_at);
        e[1] = sc[k].rep_lo >= 0 && n >= sc[k].rep_lo && n <= sc[k].held_hi &&
               ((n - sc[k].rep_lo) % RC == 0);
        e[0] = sc[k].held_lo >= 0 && n >= sc[k].held_lo && n <= sc[k].held_hi;
        chk(sc[k].name, n, outs(), e);
      end
    end

    // Reset mid-LONG with button still held, then release: no gesture.
    tick(0, 1, 1, 0);
    for (int c = 0; c < 20; c++) tick(0, 1, 0, 0);
    chk("in_long_held", 0, {4'b0, o_held}, 5'b00001);
    tick(1, 1, 0, 0);
    chk("rst_mid_long", 0, outs(), 5'b0);
    tick(0, 1, 0, 0);
    for (int c = 0; c < 25; c++) begin
      tick(0, 1, 0, 0);
      chk("held_over_reset", c, outs(), 5'b0);
    end
    tick(0, 0, 0, 1);
    for (int c = 0; c < 20; c++) begin
      tick(0, 0, 0, 0);
      chk("no_gesture", c, outs(), 5'b0);
    end
    nshort = 0;
    tick(0, 1, 1, 0);
    for (int c = 0; c < 4; c++) tick(0, 1, 0, 0);
    tick(0, 0, 0, 1);
    for (int c = 0; c < 12; c++) begin
      tick(0, 0, 0, 0);
      if (o_short) nshort++;
    end
    chk("post_rst_short_cnt", 0, 5'(nshort), 5'd1);

    // Random debounced activity with occasional glitches and resets.
    lvl = 0; dur = 5;
    for (int c = 0; c < 4000; c++) begin
      logic dn, up;
      dn = 0; up = 0;
      if ($urandom_range(0, 499) == 0) begin
        tick(1, lvl, 0, 0);
        continue;
      end
      if (dur == 0) begin
        lvl = ~lvl;
        dn = lvl; up = ~lvl;
        dur = $urandom_range(0, 3) == 0 ? $urandom_range(14, 40) : $urandom_range(1, 12);
      end else begin
        dur--;
        if ($urandom_range(0, 63) == 0) begin dn = 1; up = 1; end
      end
      tick(0, lvl, dn, up);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
